// File: rtl/seq_onehot_decoder_if.sv
// seq_onehot_decoder_if: select handshake, scan control and decoded outputs of seq_onehot_decoder
// Ports: master drives en/mode/sel_valid/sel/dwell; slave drives sel_ready/dec_out/dec_idx/wrap
interface seq_onehot_decoder_if #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
);
  localparam int OUT_W = 1 << SEL_W;
  logic               en;
  logic               mode;
  logic               sel_valid;
  logic               sel_ready;
  logic [SEL_W-1:0]   sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   dec_out;
  logic [SEL_W-1:0]   dec_idx;
  logic               wrap;
  modport master (
    output en, mode, sel_valid, sel, dwell,
    input  sel_ready, dec_out, dec_idx, wrap
  );
  modport slave (
    input  en, mode, sel_valid, sel, dwell,
    output sel_ready, dec_out, dec_idx, wrap
  );
endinterface

// File: rtl/seq_onehot_decoder.sv
// seq_onehot_decoder: registered SEL_W-to-2^SEL_W one-hot decoder with DIRECT (handshake) and SCAN (walking) modes
// Ports: clk, rst_n (async active-low), bus (slave modport: en, mode, sel_valid, sel_ready, sel, dwell, dec_out, dec_idx, wrap)
// Config: define DECODER_SCAN_EN to build the SCAN state, dwell counter and wrap pulse; otherwise mode/dwell are ignored
module seq_onehot_decoder #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  seq_onehot_decoder_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;
  logic hs;
  assign hs = bus.sel_valid & bus.sel_ready;
`ifdef DECODER_SCAN_EN
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t             state;
  logic [DWELL_W-1:0] cnt;
  assign bus.sel_ready = bus.en & ~bus.mode & (state != SCAN);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      bus.dec_out <= '0;
      bus.dec_idx <= '0;
      bus.wrap    <= 1'b0;
      cnt         <= '0;
    end else if (!bus.en) begin
      state       <= IDLE;
      bus.dec_out <= '0;
      bus.dec_idx <= '0;
      bus.wrap    <= 1'b0;
      cnt         <= '0;
    end else begin
      bus.wrap <= 1'b0;
      case (state)
        IDLE, DIRECT:
          if (bus.mode) begin
            state       <= SCAN;
            bus.dec_idx <= '0;
            bus.dec_out <= OUT_W'(1);
            cnt         <= bus.dwell;
          end else if (hs) begin
            state       <= DIRECT;
            bus.dec_idx <= bus.sel;
            bus.dec_out <= OUT_W'(1) << bus.sel;
          end
        default:
          if (!bus.mode) begin
            // leave SCAN holding the line currently shown
            state <= DIRECT;
          end else if (cnt == '0) begin
            bus.dec_idx <= bus.dec_idx + SEL_W'(1);
            bus.dec_out <= {bus.dec_out[OUT_W-2:0], bus.dec_out[OUT_W-1]};
            bus.wrap    <= (bus.dec_idx == SEL_W'(OUT_W - 1));
            cnt         <= bus.dwell;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
      endcase
    end
`else
  typedef enum logic {IDLE, DIRECT} state_t;
  state_t state;
  logic   unused_ok;
  assign unused_ok     = ^{bus.mode, bus.dwell, state};
  assign bus.sel_ready = bus.en;
  assign bus.wrap      = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      bus.dec_out <= '0;
      bus.dec_idx <= '0;
    end else if (!bus.en) begin
      state       <= IDLE;
      bus.dec_out <= '0;
      bus.dec_idx <= '0;
    end else if (hs) begin
      state       <= DIRECT;
      bus.dec_idx <= bus.sel;
      bus.dec_out <= OUT_W'(1) << bus.sel;
    end
`endif
endmodule
